int_div_wb_buffer: RTL and testbench

- Downstream of int_divider: pairs each divider result with the destination register tag captured at issue, buffers it, and presents tagged results to the writeback arbiter over a valid/ready handshake.
- Decouples divider completion from writeback back-pressure.
- Drops results whose destination is x0.
- Throttles issue when its tag queue is full.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/int_div_wb_buffer_sync_fifo.sv | 61 ++++++
 rtl/int_div_wb_buffer.sv | 86 ++++++++
 tb/tb_int_div_wb_buffer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-wide types: register address width and the tagged writeback
// bundle exchanged with the writeback arbiter.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_tagged_t;

endpackage

// File: rtl/int_div_wb_buffer_sync_fifo.sv
// Small synchronous FIFO with async active-low reset and synchronous flush.
// A push while full is dropped even if a pop happens in the same cycle.
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/int_div_wb_buffer.sv
// Pairs divider results with destination tags captured at issue, drops x0
// results, and presents tagged results to writeback over valid/ready.
module int_div_wb_buffer
  import cpu_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = REG_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     iss_valid,
  input  logic                     iss_ready,
  input  logic [TAG_W-1:0]         iss_rd,
  output logic                     iss_stall,
  input  logic                     res_valid,
  output logic                     res_ready,
  input  logic [N-1:0]             res_data,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [TAG_W-1:0]         wb_rd,
  output logic [N-1:0]             wb_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; wb_rd/wb_data hold while wb_valid && !wb_ready.

  logic [$clog2(DEPTH):0] tag_count;
  logic [$clog2(DEPTH):0] res_count;
  logic                   tag_full, tag_empty;
  logic                   res_full, res_empty;
  logic                   tag_push, res_accept, res_push;
  logic                   proto_err;
  logic                   head_live, head_zero, pop;

  assign iss_stall  = tag_full;
  assign res_ready  = !res_full;
  assign tag_push   = iss_valid && iss_ready && !iss_stall && !flush;
  assign res_accept = res_valid && res_ready && !flush;

  // A result with no outstanding tag has nothing to pair with.
  assign proto_err  = res_accept && (res_count == tag_count);
  assign res_push   = res_accept && !proto_err;

  assign head_live  = !res_empty && !tag_empty;
  assign head_zero  = (wb_rd == '0);
  assign wb_valid   = head_live && !head_zero && !flush;
  assign pop        = !flush && head_live && (head_zero || wb_ready);
  assign count      = res_count;

  sync_fifo #(.W(TAG_W), .DEPTH(DEPTH)) u_tag_q (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (tag_push),
    .pop   (pop),
    .wdata (iss_rd),
    .rdata (wb_rd),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  sync_fifo #(.W(N), .DEPTH(DEPTH)) u_res_q (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (res_push),
    .pop   (pop),
    .wdata (res_data),
    .rdata (wb_data),
    .full  (res_full),
    .empty (res_empty),
    .count (res_count)
  );

  // Sticky until reset; flush leaves it alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         err <= 1'b0;
    else if (proto_err) err <= 1'b1;
  end

endmodule

// File: tb/tb_int_div_wb_buffer.sv
// Randomized + directed bench for int_div_wb_buffer with a queue-based
// reference model and an expected-writeback scoreboard.
module tb_int_div_wb_buffer;

  localparam int N     = 32;
  localparam int DEPTH = 2;
  localparam int TAG_W = 5;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             iss_valid;
  logic             iss_ready;
  logic [TAG_W-1:0] iss_rd;
  logic             iss_stall;
  logic             res_valid;
  logic             res_ready;
  logic [N-1:0]     res_data;
  logic             wb_valid;
  logic             wb_ready;
  logic [TAG_W-1:0] wb_rd;
  logic [N-1:0]     wb_data;
  logic [CW-1:0]    count;
  logic             err;

  int checks = 0;
  int fails  = 0;

  // Reference model: outstanding tags, buffered results, expected writebacks.
  logic [TAG_W-1:0]   m_tags[$];
  logic [N-1:0]       m_res[$];
  logic [TAG_W+N-1:0] exp_q[$];
  bit                 m_err;
  bit                 m_stall, m_rrdy, m_vld, m_pop;
  int                 m_idx;

  int_div_wb_buffer #(.N(N), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .iss_valid (iss_valid),
    .iss_ready (iss_ready),
    .iss_rd    (iss_rd),
    .iss_stall (iss_stall),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .count     (count),
    .err       (err)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input bit iv, input bit ir, input logic [TAG_W-1:0] rd,
                     input bit rv, input logic [N-1:0] d, input bit wr, input bit fl);
    iss_valid = iv;
    iss_ready = ir;
    iss_rd    = rd;
    res_valid = rv;
    res_data  = d;
    wb_ready  = wr;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit wr, input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, '0, wr, 0);
  endtask

  task automatic issue(input logic [TAG_W-1:0] rd, input bit wr);
    cyc(1, 1, rd, 0, '0, wr, 0);
  endtask

  task automatic result(input logic [N-1:0] d, input bit wr);
    cyc(0, 0, '0, 1, d, wr, 0);
  endtask

  task automatic rand_cycles(input int n);
    bit               iv, ir, rv, wr, fl;
    logic [TAG_W-1:0] rd;
    logic [N-1:0]     d;
    for (int i = 0; i < n; i++) begin
      iv = 1'($urandom_range(0, 1));
      ir = ($urandom_range(0, 3) != 0);
      rd = ($urandom_range(0, 4) == 0) ? '0 : TAG_W'($urandom_range(1, 31));
      rv = (m_res.size() < m_tags.size()) && ($urandom_range(0, 2) != 0);
      d  = $urandom;
      wr = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 39) == 0);
      cyc(iv, ir, rd, rv, d, wr, fl);
    end
  endtask

  // ---------------- reference model ----------------
  // Checks outputs against the current model state, then advances the model
  // by what the coming rising edge does.
  always @(negedge clk) begin
    if (!reset) begin
      m_tags.delete();
      m_res.delete();
      exp_q.delete();
      m_err = 1'b0;
    end else begin
      m_stall = (m_tags.size() == DEPTH);
      m_rrdy  = (m_res.size() != DEPTH);
      m_vld   = (m_res.size() != 0) && (m_tags[0] != '0) && !flush;
      chk("iss_stall", 64'(iss_stall), 64'(m_stall));
      chk("res_ready", 64'(res_ready), 64'(m_rrdy));
      chk("count", 64'(count), 64'(m_res.size()));
      chk("err", 64'(err), 64'(m_err));
      chk("wb_valid", 64'(wb_valid), 64'(m_vld));
      if (m_vld) begin
        chk("head_rd", 64'(wb_rd), 64'(m_tags[0]));
        chk("head_data", 64'(wb_data), 64'(m_res[0]));
      end
      if (flush) begin
        m_tags.delete();
        m_res.delete();
        exp_q.delete();
      end else begin
        m_pop = (m_res.size() != 0) && ((m_tags[0] == '0) || wb_ready);
        if (res_valid && m_rrdy) begin
          if (m_res.size() == m_tags.size()) begin
            m_err = 1'b1;
          end else begin
            m_idx = m_res.size();
            if (m_tags[m_idx] != '0) exp_q.push_back({m_tags[m_idx], res_data});
            m_res.push_back(res_data);
          end
        end
        if (iss_valid && iss_ready && !m_stall) m_tags.push_back(iss_rd);
        if (m_pop) begin
          void'(m_tags.pop_front());
          void'(m_res.pop_front());
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [TAG_W+N-1:0] e;
    if (reset && wb_valid && wb_ready) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", 64'(wb_rd), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wb_rd", 64'(wb_rd), 64'(e[TAG_W+N-1:N]));
        chk("wb_data", 64'(wb_data), 64'(e[N-1:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; flush = 1'b0; iss_valid = 1'b0; iss_ready = 1'b0; iss_rd = '0;
    res_valid = 1'b0; res_data = '0; wb_ready = 1'b0;
    #2;
    chk("rst_wb_valid", 64'(wb_valid), 0);
    chk("rst_wb_rd", 64'(wb_rd), 0);
    chk("rst_wb_data", 64'(wb_data), 0);
    chk("rst_count", 64'(count), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_iss_stall", 64'(iss_stall), 0);
    chk("rst_res_ready", 64'(res_ready), 1);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    idle(1, 1);

    // single op: rd=7, result 5 two cycles after issue
    issue(7, 1);
    idle(1, 1);
    result(32'h0000_0005, 1);
    idle(1, 3);

    // back-pressure: two entries held, then drained in order
    issue(3, 0);
    issue(4, 0);
    result(32'h11, 0);
    result(32'h22, 0);
    chk("bp_res_ready", 64'(res_ready), 0);
    chk("bp_iss_stall", 64'(iss_stall), 1);
    idle(0, 2);
    chk("bp_hold_rd", 64'(wb_rd), 3);
    chk("bp_hold_data", 64'(wb_data), 32'h11);
    idle(1, 3);

    // x0 drop
    issue(0, 1);
    issue(9, 1);
    result(32'hDEAD, 1);
    result(32'h1234, 1);
    idle(1, 3);

    // flush with a result offered in the flush cycle
    issue(1, 0);
    issue(2, 0);
    result(32'hA, 0);
    result(32'hB, 0);
    cyc(0, 0, '0, 1, 32'hC, 0, 1);
    chk("fl_count", 64'(count), 0);
    chk("fl_iss_stall", 64'(iss_stall), 0);
    idle(1, 2);
    // one entry buffered + one tag pending, flush while result is accepted
    issue(6, 0);
    issue(8, 0);
    result(32'hE, 0);
    cyc(0, 0, '0, 1, 32'hF, 0, 1);
    idle(1, 2);

    // protocol error: result with no tag outstanding; err survives flush
    result(32'h99, 1);
    chk("perr_err", 64'(err), 1);
    chk("perr_count", 64'(count), 0);
    idle(1, 1);
    cyc(0, 0, '0, 0, '0, 1, 1);
    chk("perr_err_flush", 64'(err), 1);
    idle(1, 2);

    rand_cycles(400);
    idle(1, 4);

    // asynchronous reset while a result is being presented
    issue(5, 0);
    result(32'h55, 0);
    iss_valid = 1'b0; res_valid = 1'b0; flush = 1'b0;
    chk("ar_pre_valid", 64'(wb_valid), 1);
    #2 reset = 1'b0;
    #1;
    chk("ar_wb_valid", 64'(wb_valid), 0);
    chk("ar_wb_rd", 64'(wb_rd), 0);
    chk("ar_wb_data", 64'(wb_data), 0);
    chk("ar_count", 64'(count), 0);
    chk("ar_err", 64'(err), 0);
    chk("ar_res_ready", 64'(res_ready), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(1, 1);

    rand_cycles(200);
    idle(1, 6);
    chk("drain_exp_q", 64'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
